i2c_reg_slave: RTL
==================

// Module: i2c_reg_slave
// PURPOSE
//  I2C write-only register responder for WM8978-style 16-bit frames (7-bit reg addr + 9-bit data).
//  Sits on the SCL/SDA bus opposite an I2C master and its register-config sequencer.
//  Decodes frames, ACKs them and updates an internal 9-bit register file.
//  Register contents are exposed on a read port and a write-strobe side channel.
//  Used as a bench codec model and as the target when the FPGA acts as an I2C peripheral.
// PARAMETERS
//  SLAVE_ADDR  7'h1A  7-bit device address responded to (WM8978 = 0011010)
//  REG_DEPTH   64     number of implemented registers; addresses >= REG_DEPTH are ACKed but dropped
// PORTS
//  clk          in   1   system clock; must be >= 16x SCL frequency
//  rst_n        in   1   synchronous, active-low reset
//  scl          in   1   I2C clock from bus (asynchronous)
//  sda_in       in   1   I2C data from bus (asynchronous)
//  sda_oe       out  1   1 = pull SDA low (open-drain ACK); 0 = release
//  wr_en        out  1   one-cycle pulse when a frame commits
//  wr_addr      out  7   register address of the committed frame
//  wr_data      out  9   data of the committed frame
//  wr_err       out  1   sticky; set on commit to address >= REG_DEPTH; cleared by rst_n only
//  busy         out  1   1 between START and STOP
//  rd_addr      in   7   register-file read address
//  rd_data      out  9   regs[rd_addr], registered; 1-cycle latency; 0 if rd_addr >= REG_DEPTH
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge): all regs cleared to 0; state IDLE.
//   sda_oe, wr_en, wr_addr, wr_data, wr_err, busy and rd_data all driven 0.
//   A reset mid-frame abandons the frame; no write commits.
//  Inputs: 2-FF sync on scl/sda_in plus one history FF each.
//   SCL rise/fall and SDA edges are derived from the synced samples only.
//  START: sync SDA 1->0 while SCL high. Repeated START in any state -> ADDR with bit counter 0; busy=1.
//  STOP: sync SDA 0->1 while SCL high. Any state -> IDLE; busy=0; sda_oe=0.
//   A partial frame is discarded; no wr_en.
//  Bits are sampled on SCL rise, MSB first. sda_oe changes only on SCL fall.
//  States and transitions:
//   IDLE -> ADDR on START.
//   ADDR: 8 bits {addr[6:0], rw}.
//    If addr==SLAVE_ADDR and rw==0 -> ACK_A.
//    Otherwise (mismatch, or a read request) -> IGNORE; no ACK is driven.
//   ACK_A: on the SCL fall after bit 8, sda_oe=1; on the next SCL fall, sda_oe=0 -> HI.
//   HI: 8 bits, latched as {reg_addr[6:0], data[8]} -> ACK_H (same ACK timing).
//   ACK_H -> LO.
//   LO: 8 bits, latched as data[7:0] -> ACK_L.
//   ACK_L: the ACK is driven on the SCL fall after bit 8.
//    On the SCL fall that releases the ACK, the frame commits and state -> HI.
//    The next byte pair is a new, independent frame (no auto-increment).
//   IGNORE: sda_oe=0; waits only for START or STOP.
//  Commit, all in the same clk:
//   wr_en=1; wr_addr/wr_data hold the frame values until the next commit.
//   If reg_addr==0 (soft reset): all regs cleared to 0, including reg 0.
//   Else if reg_addr < REG_DEPTH: regs[reg_addr] <= data.
//   Else: no write; wr_err=1.
//  Read port: rd_data <= regs[rd_addr] every clk, giving read-before-write.
//   rd_addr equal to the commit address in the commit cycle returns the old value; the new value appears 1 clk later.
//  A START or STOP seen in the commit clk takes priority over the state transition; the commit itself still completes.
//  The bit counter is 3 bits and wraps 7->0 at each byte end; no other counters are needed.
// STRUCTURE
//  Shared header i2c_defs.vh holds:
//   state encodings (IDLE, ADDR, ACK_A, HI, ACK_H, LO, ACK_L, IGNORE);
//   the WM8978 device-address constant;
//   the 16-bit frame field positions (addr [15:9], data [8:0]).
//  Sub-module i2c_line_sync holds the synchronizers and history FFs.
//   Outputs: scl_rise, scl_fall, start_det, stop_det, sda_s.
//  The FSM, shift register and register file stay in i2c_reg_slave.
// TESTING
//  1. START, 0x34, 0x08, 0x10, STOP -> ACK on all 3 bytes; wr_en once with wr_addr=4, wr_data=0x010; rd_addr=4 then rd_data=0x010.
//  2. START, 0x36, STOP -> sda_oe stays 0 throughout; no wr_en; regs unchanged.
//  3. START, 0x35 (read) -> NACK; the following bytes are ignored; busy stays 1 until STOP.
//  4. START, 0x34, 0x68, STOP (frame cut short) -> no wr_en; regs[52] unchanged.
//  5. Frames R52=0x09E and R53=0x19E back-to-back, then START, 0x34, 0x00, 0x01, STOP
//     -> 3 wr_en pulses; after the R0 write, regs[52]=regs[53]=0.
//  6. Write to reg 63 (REG_DEPTH=64) -> stored, wr_err=0.
//     Then reset asserted mid-byte -> sda_oe=0, busy=0 and all regs 0 on the next clk.
//     Then a write to reg 70 with REG_DEPTH=64 -> ACKed, wr_err=1.

Source files
------------

// File: rtl/i2c_reg_slave_pkg.sv
// Shared types and constants for the I2C write-only register responder.
// Holds the FSM state encoding, the WM8978 device address and the 16-bit frame layout.
package i2c_reg_slave_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_A,
    ST_HI,
    ST_ACK_H,
    ST_LO,
    ST_ACK_L,
    ST_IGNORE
  } state_e;

  localparam logic [6:0] WM8978_ADDR = 7'h1A;

  // Frame as sent on the wire: register address in [15:9], data in [8:0].
  typedef struct packed {
    logic [6:0] addr;
    logic [8:0] data;
  } frame_t;

endpackage

// File: rtl/i2c_reg_slave_if.sv
// I2C bus as seen by the responder: SCL and resolved SDA in, open-drain pull-down out.
interface i2c_reg_slave_if;

  logic scl;
  logic sda_in;
  logic sda_oe;

  modport master (output scl, output sda_in, input sda_oe);
  modport slave  (input scl, input sda_in, output sda_oe);

endinterface

// File: rtl/i2c_reg_slave_line_sync.sv
// Two-flop synchronizers plus one history flop on SCL and SDA; derives SCL edges
// and START/STOP conditions purely from the synchronized samples.
module i2c_reg_slave_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  // Bit 0 is the metastable stage, bit 1 the synced sample, bit 2 the previous synced sample.
  logic [2:0] scl_q;
  logic [2:0] sda_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[1:0], scl};
      sda_q <= {sda_q[1:0], sda};
    end
  end

  assign scl_rise  =  scl_q[1] & ~scl_q[2];
  assign scl_fall  = ~scl_q[1] &  scl_q[2];
  assign start_det =  scl_q[1] &  scl_q[2] &  sda_q[2] & ~sda_q[1];
  assign stop_det  =  scl_q[1] &  scl_q[2] & ~sda_q[2] &  sda_q[1];
  assign sda_s     =  sda_q[1];

endmodule

// File: rtl/i2c_reg_slave.sv
// I2C write-only responder for WM8978-style frames: decodes {reg[6:0], data[8:0]}
// byte pairs, ACKs them and commits them into a 9-bit register file.
module i2c_reg_slave
  import i2c_reg_slave_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = WM8978_ADDR,
  parameter int         REG_DEPTH  = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  i2c_reg_slave_if.slave bus,
  output logic           wr_en,
  output logic [6:0]     wr_addr,
  output logic [8:0]     wr_data,
  output logic           wr_err,
  output logic           busy,
  input  logic [6:0]     rd_addr,
  output logic [8:0]     rd_data
);

  localparam int         AW      = (REG_DEPTH > 1) ? $clog2(REG_DEPTH) : 1;
  localparam logic [7:0] DEPTH_L = 8'(REG_DEPTH);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_reg_slave_line_sync u_line_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .scl       (bus.scl),
    .sda       (bus.sda_in),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  state_e     state_q;
  logic [2:0] bit_cnt_q;
  logic [6:0] shift_q;
  frame_t     frame_q;
  logic       sda_oe_q, busy_q, wr_en_q, wr_err_q;
  logic [6:0] wr_addr_q;
  logic [8:0] wr_data_q, rd_data_q;
  logic [8:0] regs_q [REG_DEPTH];

  logic [7:0] byte_d;
  logic       commit, commit_in_range, rd_in_range;

  assign byte_d          = {shift_q, sda_s};
  // The SCL fall that releases the third ACK is the commit point.
  assign commit          = (state_q == ST_ACK_L) && scl_fall && sda_oe_q;
  assign commit_in_range = {1'b0, frame_q.addr} < DEPTH_L;
  assign rd_in_range     = {1'b0, rd_addr} < DEPTH_L;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      frame_q   <= '0;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      if (commit) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= frame_q.addr;
        wr_data_q <= frame_q.data;
        if (!commit_in_range) wr_err_q <= 1'b1;
      end

      // Bus conditions override the byte FSM; a commit above still completes.
      if (stop_det) begin
        state_q   <= ST_IDLE;
        busy_q    <= 1'b0;
        sda_oe_q  <= 1'b0;
        bit_cnt_q <= '0;
      end else if (start_det) begin
        state_q   <= ST_ADDR;
        busy_q    <= 1'b1;
        sda_oe_q  <= 1'b0;
        bit_cnt_q <= '0;
      end else begin
        unique case (state_q)
          ST_ADDR, ST_HI, ST_LO: begin
            if (scl_rise) begin
              shift_q   <= byte_d[6:0];
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (bit_cnt_q == 3'd7) begin
                if (state_q == ST_ADDR) begin
                  state_q <= (byte_d[7:1] == SLAVE_ADDR && !byte_d[0]) ? ST_ACK_A : ST_IGNORE;
                end else if (state_q == ST_HI) begin
                  frame_q[15:8] <= byte_d;
                  state_q       <= ST_ACK_H;
                end else begin
                  frame_q[7:0] <= byte_d;
                  state_q      <= ST_ACK_L;
                end
              end
            end
          end
          ST_ACK_A, ST_ACK_H, ST_ACK_L: begin
            // First fall drives the ACK, the second releases it and moves on.
            if (scl_fall) begin
              sda_oe_q <= !sda_oe_q;
              if (sda_oe_q) state_q <= (state_q == ST_ACK_H) ? ST_LO : ST_HI;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // NOTE: the register file is reset explicitly because reset and soft reset must both clear it.
  always_ff @(posedge clk) begin
    if (!rst_n || (commit && frame_q.addr == 7'd0)) begin
      for (int i = 0; i < REG_DEPTH; i++) regs_q[i] <= '0;
    end else if (commit && commit_in_range) begin
      regs_q[frame_q.addr[AW-1:0]] <= frame_q.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rd_data_q <= '0;
    else        rd_data_q <= rd_in_range ? regs_q[rd_addr[AW-1:0]] : '0;
  end

  assign bus.sda_oe = sda_oe_q;
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign wr_err     = wr_err_q;
  assign busy       = busy_q;
  assign rd_data    = rd_data_q;

endmodule
